// File: rtl/seven_segment_cntrl.sv
// Registered 3-bit to seven-segment decoder for the multiplier step count.
// Codes 0..3 show "0".."3"; codes 4..7 show "E". One cycle of latency.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high; blanks the digit
//   inp[2:0]      value to display (0..7)
//   seg_a..seg_g  segment drives (a top, b top right, c bottom right,
//                 d bottom, e bottom left, f top left, g middle)
// Parameter ACTIVE_LOW: 0 = segment lit on 1, 1 = all outputs inverted.
module seven_segment_cntrl #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] inp,
    output logic       seg_a,
    output logic       seg_b,
    output logic       seg_c,
    output logic       seg_d,
    output logic       seg_e,
    output logic       seg_f,
    output logic       seg_g
);

    // Segment vectors are ordered {a,b,c,d,e,f,g}, a in the MSB.
    localparam logic [6:0] GLYPH_0 = 7'b1111110;
    localparam logic [6:0] GLYPH_1 = 7'b0110000;
    localparam logic [6:0] GLYPH_2 = 7'b1101101;
    localparam logic [6:0] GLYPH_3 = 7'b1111001;
    localparam logic [6:0] GLYPH_E = 7'b1001111;

    // Level that leaves every segment dark for the selected polarity.
    localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

    logic [6:0] lit;
    logic [6:0] drive;
    logic [6:0] seg_q;

    // Anything outside 0..3, including unknowns, falls to "E".
    always_comb begin
        lit = GLYPH_E;
        case (inp)
            3'd0:    lit = GLYPH_0;
            3'd1:    lit = GLYPH_1;
            3'd2:    lit = GLYPH_2;
            3'd3:    lit = GLYPH_3;
            default: lit = GLYPH_E;
        endcase
    end

    assign drive = ACTIVE_LOW ? ~lit : lit;

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= BLANK;
        end else begin
            seg_q <= drive;
        end
    end

    assign seg_a = seg_q[6];
    assign seg_b = seg_q[5];
    assign seg_c = seg_q[4];
    assign seg_d = seg_q[3];
    assign seg_e = seg_q[2];
    assign seg_f = seg_q[1];
    assign seg_g = seg_q[0];

endmodule

// File: tb/tb_seven_segment_cntrl.sv
// Directed bench for seven_segment_cntrl.
// Checks both polarities side by side against a hand-written glyph table.
module tb_seven_segment_cntrl;

    logic       clk;
    logic       reset;
    logic [2:0] inp;

    logic a0, b0, c0, d0, e0, f0, g0;
    logic a1, b1, c1, d1, e1, f1, g1;

    int tests;
    int fails;

    seven_segment_cntrl #(.ACTIVE_LOW(1'b0)) dut_hi (
        .clk   (clk),
        .reset (reset),
        .inp   (inp),
        .seg_a (a0),
        .seg_b (b0),
        .seg_c (c0),
        .seg_d (d0),
        .seg_e (e0),
        .seg_f (f0),
        .seg_g (g0)
    );

    seven_segment_cntrl #(.ACTIVE_LOW(1'b1)) dut_lo (
        .clk   (clk),
        .reset (reset),
        .inp   (inp),
        .seg_a (a1),
        .seg_b (b1),
        .seg_c (c1),
        .seg_d (d1),
        .seg_e (e1),
        .seg_f (f1),
        .seg_g (g1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0:       glyph = 7'b1111110;
            1:       glyph = 7'b0110000;
            2:       glyph = 7'b1101101;
            3:       glyph = 7'b1111001;
            default: glyph = 7'b1001111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs,
                       input logic [6:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_both(input string tag, input logic [6:0] lit_exp);
        chk({tag, "_hi"}, {a0, b0, c0, d0, e0, f0, g0}, lit_exp);
        chk({tag, "_lo"}, {a1, b1, c1, d1, e1, f1, g1}, ~lit_exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        inp   = 3'd3;

        // Reset holds for two edges with a nonzero inp pending.
        tick();
        chk_both("reset_1", 7'b0000000);
        tick();
        chk_both("reset_2", 7'b0000000);

        // First edge after release loads inp=3 directly.
        reset = 1'b0;
        tick();
        chk_both("release", glyph(3));

        // In-range sweep, one value per cycle.
        for (int v = 0; v < 4; v++) begin
            inp = 3'(v);
            tick();
            chk_both($sformatf("digit_%0d", v), glyph(v));
        end

        // Out of range shows "E".
        for (int v = 4; v < 8; v++) begin
            inp = 3'(v);
            tick();
            chk_both($sformatf("err_%0d", v), 7'b1001111);
        end

        // Input change between edges must not reach the outputs early.
        inp = 3'd1;
        tick();
        chk_both("lat_pre", 7'b0110000);
        inp = 3'd2;
        #2;
        chk_both("lat_hold", 7'b0110000);
        tick();
        chk_both("lat_post", 7'b1101101);

        // Mid-operation reset blanks for one cycle, then recovers.
        reset = 1'b1;
        tick();
        chk_both("mid_reset", 7'b0000000);
        reset = 1'b0;
        tick();
        chk_both("mid_release", 7'b1101101);

        // Back-to-back changes: each value shows on its own cycle.
        inp = 3'd0;
        tick();
        chk_both("b2b_0", 7'b1111110);
        inp = 3'd5;
        tick();
        chk_both("b2b_5", 7'b1001111);
        inp = 3'd3;
        tick();
        chk_both("b2b_3", 7'b1111001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
